// File: rtl/mem_readback.sv
// Streams wordCount words from a data-memory read port starting at baseAddress,
// holding the port across consumer backpressure. Optional: MEM_READBACK_CHECKSUM_EN.
module mem_readback #(
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned READ_LAT    = 2,
    parameter int unsigned WORD_STRIDE = 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic [31:0]      baseAddress,
    input  logic [LEN_W-1:0] wordCount,
    output logic [31:0]      memAddress,
    input  logic [31:0]      memReadData,
    output logic             ownsMem,
    output logic             busy,
    output logic [31:0]      outData,
    output logic             outValid,
    input  logic             outReady,
    output logic             outLast,
    output logic             done
`ifdef MEM_READBACK_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    localparam int unsigned LAT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               armed;
    logic [31:0]        addr;
    logic [LEN_W-1:0]   remaining;
    logic [LAT_W-1:0]   lat_cnt;
    logic               accept;
    logic               xfer;
    logic               last_word;

    assign memAddress = addr;
    assign last_word  = (remaining == LEN_W'(1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        ownsMem    = 1'b0;
        busy       = 1'b1;
        outValid   = 1'b0;
        outLast    = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        xfer       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && armed) begin
                    accept     = 1'b1;
                    state_next = (wordCount == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                ownsMem    = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                ownsMem = 1'b1;
                if (lat_cnt == '0) state_next = S_HOLD;
            end
            S_HOLD: begin
                ownsMem  = 1'b1;
                outValid = 1'b1;
                outLast  = last_word;
                if (outReady) begin
                    xfer       = 1'b1;
                    state_next = last_word ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // armed blocks a start on the first edge after reset release
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            armed     <= 1'b0;
            addr      <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
            outData   <= '0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                addr      <= baseAddress;
                remaining <= wordCount;
            end
            if (state == S_ISSUE) lat_cnt <= LAT_W'(READ_LAT - 1);
            if (state == S_WAIT) begin
                if (lat_cnt == '0) outData <= memReadData;
                else               lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (xfer) begin
                addr      <= addr + 32'(WORD_STRIDE);
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

`ifdef MEM_READBACK_CHECKSUM_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)     checksum <= '0;
        else if (accept) checksum <= '0;
        else if (xfer)   checksum <= checksum ^ outData;
    end
`endif

endmodule

// File: tb/tb_mem_readback.sv
// Directed bench for mem_readback: table of readback transactions plus
// hand sequences for reset mid-transfer, post-reset start gating and max count.
module tb_mem_readback;

    localparam int unsigned READ_LAT = 2;

    logic        clk;
    logic        resetN;
    logic        start;
    logic [31:0] baseAddress;
    logic [15:0] wordCount;
    logic [31:0] memAddress;
    logic [31:0] memReadData;
    logic        ownsMem;
    logic        busy;
    logic [31:0] outData;
    logic        outValid;
    logic        outReady;
    logic        outLast;
    logic        done;
`ifdef MEM_READBACK_CHECKSUM_EN
    logic [31:0] checksum;
    logic [31:0] s_checksum;
`endif

    logic        s_start;
    logic [31:0] s_base;
    logic [2:0]  s_count;
    logic [31:0] s_addr;
    logic [31:0] s_rdata;
    logic        s_owns;
    logic        s_busy;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic        s_done;

    int checks   = 0;
    int failures = 0;

    mem_readback #(.LEN_W(16), .READ_LAT(READ_LAT), .WORD_STRIDE(1)) u_dut (
        .clk(clk), .resetN(resetN), .start(start), .baseAddress(baseAddress),
        .wordCount(wordCount), .memAddress(memAddress), .memReadData(memReadData),
        .ownsMem(ownsMem), .busy(busy), .outData(outData), .outValid(outValid),
        .outReady(outReady), .outLast(outLast), .done(done)
`ifdef MEM_READBACK_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    mem_readback #(.LEN_W(3), .READ_LAT(READ_LAT), .WORD_STRIDE(1)) u_small (
        .clk(clk), .resetN(resetN), .start(s_start), .baseAddress(s_base),
        .wordCount(s_count), .memAddress(s_addr), .memReadData(s_rdata),
        .ownsMem(s_owns), .busy(s_busy), .outData(s_data), .outValid(s_valid),
        .outReady(s_ready), .outLast(s_last), .done(s_done)
`ifdef MEM_READBACK_CHECKSUM_EN
        , .checksum(s_checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'd500:      return 32'd42;
            32'd501:      return 32'd7;
            32'd502:      return 32'hDEADBEEF;
            32'hFFFFFFFF: return 32'h11111111;
            32'h00000000: return 32'h22222222;
            default:      return a ^ 32'hA5A5A5A5;
        endcase
    endfunction

    logic [31:0] pipe [READ_LAT];
    always @(posedge clk) begin
        pipe[0] <= mem_model(memAddress);
        for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign memReadData = pipe[READ_LAT-1];

    typedef struct {
        logic [31:0]      base;
        logic [15:0]      count;
        int unsigned      stall;
        bit               restart;
        logic [2:0][31:0] exp;
        logic [31:0]      sum;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input logic [31:0] b, input logic [15:0] c,
                                input int unsigned st, input bit rs,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] s);
        vec_t v;
        v.base = b; v.count = c; v.stall = st; v.restart = rs;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.sum = s;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned w = 0;
        int unsigned stall_left = v.stall;
        int unsigned last_xfer = 0;
        int unsigned dones = 0;
        bit finished = 0;
        bit any_owns = 0;
        @(negedge clk);
        baseAddress = v.base;
        wordCount   = v.count;
        outReady    = 1'b1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("busy_after_start", busy, 1'b1);
        for (int unsigned cyc = 1; cyc < 200 && !finished; cyc++) begin
            start = 1'b0;
            if (ownsMem) any_owns = 1;
            if (done) begin
                dones++;
                chk1("done_owns", ownsMem, 1'b0);
                chk1("done_valid", outValid, 1'b0);
                finished = 1;
            end else if (outValid) begin
                chk1("hold_owns", ownsMem, 1'b1);
                if (w >= 32'(v.count)) begin
                    chk32("extra_word", w, 32'(v.count));
                end else begin
                    chk32("out_data", outData, v.exp[w]);
                    chk32("mem_addr", memAddress, v.base + w);
                    chk1("out_last", outLast, w == 32'(v.count) - 1);
                end
                if (v.restart && w == 1) begin
                    baseAddress = 32'd700;
                    wordCount   = 16'd5;
                    start       = 1'b1;
                end
                if (stall_left > 0) begin
                    outReady = 1'b0;
                    stall_left--;
                end else begin
                    outReady = 1'b1;
                    if (v.stall == 0 && w > 0)
                        chk32("throughput", cyc - last_xfer, READ_LAT + 2);
                    last_xfer = cyc;
                    w++;
                end
            end else begin
                outReady = 1'b1;
            end
            if (!finished) @(negedge clk);
        end
        chk1("finished", finished, 1'b1);
        chk32("word_count", w, 32'(v.count));
        chk32("done_pulses", dones, 1);
        chk1("owns_seen", any_owns, v.count != 0);
`ifdef MEM_READBACK_CHECKSUM_EN
        chk32("checksum", checksum, v.sum);
`endif
        @(negedge clk);
        chk1("idle_busy", busy, 1'b0);
        chk1("done_one_cycle", done, 1'b0);
`ifdef MEM_READBACK_CHECKSUM_EN
        chk32("checksum_hold", checksum, v.sum);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int unsigned n;
        int unsigned sd;

        vecs[0] = mk(32'd500, 16'd3, 0, 0, 32'd42, 32'd7, 32'hDEADBEEF, 32'hDEADBEC2);
        vecs[1] = mk(32'd500, 16'd3, 5, 0, 32'd42, 32'd7, 32'hDEADBEEF, 32'hDEADBEC2);
        vecs[2] = mk(32'hFFFFFFFF, 16'd2, 0, 0, 32'h11111111, 32'h22222222, 32'h0, 32'h33333333);
        vecs[3] = mk(32'd0, 16'd0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[4] = mk(32'd100, 16'd1, 0, 0, 32'hA5A5A5C1, 32'h0, 32'h0, 32'hA5A5A5C1);
        vecs[5] = mk(32'd500, 16'd3, 0, 1, 32'd42, 32'd7, 32'hDEADBEEF, 32'hDEADBEC2);

        start = 0; baseAddress = '0; wordCount = '0; outReady = 1;
        s_start = 0; s_base = '0; s_count = '0; s_rdata = '0; s_ready = 1;
        resetN = 1;
        #1 resetN = 0;
        #1;
        chk32("rst_mem_addr", memAddress, 32'h0);
        chk1("rst_owns", ownsMem, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_out_data", outData, 32'h0);
        chk1("rst_valid", outValid, 1'b0);
        chk1("rst_last", outLast, 1'b0);
        chk1("rst_done", done, 1'b0);
        repeat (3) @(negedge clk);
        resetN = 1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // reset asserted in the WAIT of word 2
        @(negedge clk);
        baseAddress = 32'd500; wordCount = 16'd3; outReady = 1; start = 1;
        @(negedge clk);
        start = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (outValid) found = 1;
            else @(negedge clk);
        end
        chk1("reach_hold", found, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk1("wait2_owns", ownsMem, 1'b1);
        chk1("wait2_valid", outValid, 1'b0);
        resetN = 0;
        #1;
        chk1("midrst_owns", ownsMem, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk32("midrst_addr", memAddress, 32'h0);
        chk32("midrst_data", outData, 32'h0);
        chk1("midrst_valid", outValid, 1'b0);
        chk1("midrst_done", done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("midrst_no_done", done, 1'b0);
        end
        resetN = 1;
        start  = 1;
        @(negedge clk);
        start = 0;
        chk1("start_gated_first_edge", busy, 1'b0);
        run_vec(vecs[0]);

        // max wordCount on a 3-bit count instance
        @(negedge clk);
        s_base = 32'd0; s_count = 3'd7; s_start = 1;
        @(negedge clk);
        s_start = 0;
        n = 0; sd = 0;
        for (int i = 0; i < 100 && sd == 0; i++) begin
            if (s_valid) n++;
            if (s_done) sd++;
            else @(negedge clk);
        end
        chk32("max_count_words", n, 7);
        chk32("max_count_done", sd, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
